// File: rtl/pc_fetch_stage_if.sv
// rtl/pc_fetch_stage_if.sv - IF-stage control, instruction-memory and IF/ID bundle
interface pc_fetch_stage_if #(
  parameter int PC_W = 9
);
  logic            Stall;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            Halt_com;
  logic [31:0]     Instr_rdata;
  logic [PC_W-1:0] Instr_addr;
  logic [PC_W-1:0] Cur_PC;
  logic [PC_W-1:0] IfId_PC;
  logic [31:0]     IfId_Instr;
  logic            IfId_Valid;
  logic            Halted;
  logic            Misalign;
  logic [31:0]     Fetch_cnt;
  logic [31:0]     Flush_cnt;

  // The fetch stage itself
  modport slave (
    input  Stall, PcSel, BrPC, Halt_com, Instr_rdata,
    output Instr_addr, Cur_PC, IfId_PC, IfId_Instr, IfId_Valid,
           Halted, Misalign, Fetch_cnt, Flush_cnt
  );

  // Hazard unit, EX stage and instruction memory around it
  modport master (
    output Stall, PcSel, BrPC, Halt_com, Instr_rdata,
    input  Instr_addr, Cur_PC, IfId_PC, IfId_Instr, IfId_Valid,
           Halted, Misalign, Fetch_cnt, Flush_cnt
  );
endinterface

// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - PC register, IF/ID register and RUN/HALTED fetch FSM
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module pc_fetch_stage #(
  parameter int              PC_W      = 9,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input logic              clk,
  input logic              reset,
  pc_fetch_stage_if.slave  bus
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [0:0]      state;
  logic [PC_W-1:0] cur_pc;
  logic [PC_W-1:0] ifid_pc;
  logic [31:0]     ifid_instr;
  logic            ifid_valid;
  logic            misalign;

  logic            running;
  logic            take_redirect;
  logic            take_fetch;
  logic [PC_W-1:0] target;
  logic            unused_brpc_hi;

  assign running       = (state == ST_RUN);
  assign take_redirect = running && bus.PcSel;
  assign take_fetch    = running && !bus.PcSel && !bus.Stall;
  assign target        = {bus.BrPC[PC_W-1:2], 2'b00};
  assign unused_brpc_hi = &{1'b0, bus.BrPC[31:PC_W]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_RUN;
      cur_pc     <= RESET_PC;
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      misalign <= 1'b0;
      if (take_redirect) begin
        // Redirect beats stall; a halt redirect still loads the target PC
        cur_pc     <= target;
        ifid_pc    <= '0;
        ifid_instr <= NOP_INSTR;
        ifid_valid <= 1'b0;
        misalign   <= |bus.BrPC[1:0];
        if (bus.Halt_com) begin
          state <= ST_HALTED;
        end
      end else if (take_fetch) begin
        cur_pc     <= cur_pc + PC_W'(4);
        ifid_pc    <= cur_pc;
        ifid_instr <= bus.Instr_rdata;
        ifid_valid <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (take_fetch) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (take_redirect && !bus.Halt_com) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

  assign bus.Fetch_cnt = fetch_cnt;
  assign bus.Flush_cnt = flush_cnt;
`else
  assign bus.Fetch_cnt = 32'h0;
  assign bus.Flush_cnt = 32'h0;
`endif

  assign bus.Instr_addr = cur_pc;
  assign bus.Cur_PC     = cur_pc;
  assign bus.IfId_PC    = ifid_pc;
  assign bus.IfId_Instr = ifid_instr;
  assign bus.IfId_Valid = ifid_valid;
  assign bus.Halted     = (state == ST_HALTED);
  assign bus.Misalign   = misalign;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb/tb_pc_fetch_stage.sv - randomized self-checking bench for pc_fetch_stage
module tb_pc_fetch_stage;

  localparam int          PC_W = 9;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk;
  logic reset;
  logic [31:0] rom [128];

  pc_fetch_stage_if #(.PC_W(PC_W)) bus ();

  pc_fetch_stage #(.PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.Instr_rdata = rom[bus.Instr_addr[8:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model: PC as a plain integer address, IF/ID contents, counters
  int          m_pc;
  bit          m_halted;
  int          m_ifid_pc;
  logic [31:0] m_instr;
  bit          m_valid;
  bit          m_mis;
  int unsigned m_fetch;
  int unsigned m_flush;

  task automatic model_reset();
    m_pc = 0; m_halted = 0; m_ifid_pc = 0; m_instr = NOP; m_valid = 0;
    m_mis = 0; m_fetch = 0; m_flush = 0;
  endtask

  task automatic step(input logic st, input logic ps, input logic [31:0] br, input logic hc);
    bus.Stall = st; bus.PcSel = ps; bus.BrPC = br; bus.Halt_com = hc;
    m_mis = 0;
    if (!m_halted) begin
      if (ps) begin
        m_mis     = (br % 4) != 0;
        m_pc      = int'(br % 512) - int'(br % 4);
        m_valid   = 0;
        m_instr   = NOP;
        m_ifid_pc = 0;
        if (hc) m_halted = 1;
        else    m_flush++;
      end else if (!st) begin
        m_ifid_pc = m_pc;
        m_instr   = rom[m_pc / 4];
        m_valid   = 1;
        m_fetch++;
        m_pc      = (m_pc + 4) % 512;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.Stall = 0; bus.PcSel = 0; bus.BrPC = 0; bus.Halt_com = 0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    bus.Stall = 0; bus.PcSel = 0; bus.BrPC = 0; bus.Halt_com = 0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.Cur_PC !== 9'h000 || bus.IfId_Valid !== 1'b0 || bus.IfId_Instr !== NOP ||
        bus.IfId_PC !== 9'h000 || bus.Halted !== 1'b0 || bus.Misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h ifid_pc=%h instr=%h valid=%b halted=%b mis=%b required pc=000 ifid_pc=000 instr=%h valid=0 halted=0 mis=0",
               bus.Cur_PC, bus.IfId_PC, bus.IfId_Instr, bus.IfId_Valid, bus.Halted, bus.Misalign, NOP);
    end
    n_checks++;
    if (bus.Fetch_cnt !== 32'h0 || bus.Flush_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_counters: fetch=%0d flush=%0d required 0 0", bus.Fetch_cnt, bus.Flush_cnt);
    end
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 6; k++) begin
      // Halt_com without PcSel must be ignored
      step(1'b0, 1'b0, 32'h0000_0040, (k == 3));
      n_checks++;
      if (bus.Cur_PC !== 9'(4 * k) || bus.Instr_addr !== 9'(4 * k) || bus.IfId_Valid !== 1'b1 ||
          bus.IfId_PC !== 9'(4 * (k - 1)) || bus.IfId_Instr !== 32'(k - 1) || bus.Halted !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_fetch[%0d]: pc=%h addr=%h ifid_pc=%h instr=%h valid=%b halted=%b required pc=%h ifid_pc=%h instr=%h valid=1 halted=0",
                 k, bus.Cur_PC, bus.Instr_addr, bus.IfId_PC, bus.IfId_Instr, bus.IfId_Valid, bus.Halted,
                 9'(4 * k), 9'(4 * (k - 1)), 32'(k - 1));
      end
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b1, 32'h0000_01FC, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (bus.Cur_PC !== 9'h000 || bus.IfId_PC !== 9'h1FC || bus.IfId_Valid !== 1'b1 || bus.IfId_Instr !== rom[127]) begin
      n_fail++;
      $display("FAIL pc_wrap: pc=%h ifid_pc=%h valid=%b instr=%h required pc=000 ifid_pc=1fc valid=1 instr=%h",
               bus.Cur_PC, bus.IfId_PC, bus.IfId_Valid, bus.IfId_Instr, rom[127]);
    end
  endtask

  task automatic test_stall();
    step(1'b0, 1'b1, 32'h0000_0010, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      n_checks++;
      if (bus.Cur_PC !== 9'h010 || bus.IfId_Valid !== 1'b0 || bus.IfId_Instr !== NOP) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: pc=%h valid=%b instr=%h required pc=010 valid=0 instr=%h",
                 k, bus.Cur_PC, bus.IfId_Valid, bus.IfId_Instr, NOP);
      end
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (bus.Cur_PC !== 9'h014 || bus.IfId_PC !== 9'h010 || bus.IfId_Valid !== 1'b1 || bus.IfId_Instr !== rom[4]) begin
      n_fail++;
      $display("FAIL stall_resume: pc=%h ifid_pc=%h valid=%b instr=%h required pc=014 ifid_pc=010 valid=1 instr=%h",
               bus.Cur_PC, bus.IfId_PC, bus.IfId_Valid, bus.IfId_Instr, rom[4]);
    end
  endtask

  task automatic test_redirect_stall();
    step(1'b1, 1'b1, 32'h0000_0123, 1'b0);
    n_checks++;
    if (bus.Cur_PC !== 9'h120 || bus.IfId_Valid !== 1'b0 || bus.IfId_Instr !== NOP || bus.Misalign !== 1'b1) begin
      n_fail++;
      $display("FAIL redirect_stall: pc=%h valid=%b instr=%h mis=%b required pc=120 valid=0 instr=%h mis=1",
               bus.Cur_PC, bus.IfId_Valid, bus.IfId_Instr, bus.Misalign, NOP);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (bus.Misalign !== 1'b0 || bus.IfId_PC !== 9'h120 || bus.IfId_Valid !== 1'b1 || bus.Cur_PC !== 9'h124) begin
      n_fail++;
      $display("FAIL redirect_latency: mis=%b ifid_pc=%h valid=%b pc=%h required mis=0 ifid_pc=120 valid=1 pc=124",
               bus.Misalign, bus.IfId_PC, bus.IfId_Valid, bus.Cur_PC);
    end
  endtask

  task automatic test_halt();
    step(1'b0, 1'b1, 32'h0000_0040, 1'b1);
    n_checks++;
    if (bus.Cur_PC !== 9'h040 || bus.Halted !== 1'b1 || bus.IfId_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_enter: pc=%h halted=%b valid=%b required pc=040 halted=1 valid=0",
               bus.Cur_PC, bus.Halted, bus.IfId_Valid);
    end
    step(1'b0, 1'b1, 32'h0000_0080, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0081, 1'b1);
    n_checks++;
    if (bus.Cur_PC !== 9'h040 || bus.Halted !== 1'b1 || bus.IfId_Valid !== 1'b0 || bus.Misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_frozen: pc=%h halted=%b valid=%b mis=%b required pc=040 halted=1 valid=0 mis=0",
               bus.Cur_PC, bus.Halted, bus.IfId_Valid, bus.Misalign);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.Cur_PC !== 9'h000 || bus.Halted !== 1'b0 || bus.IfId_Valid !== 1'b0 || bus.IfId_Instr !== NOP ||
        bus.IfId_PC !== 9'h000 || bus.Misalign !== 1'b0 || bus.Fetch_cnt !== 32'h0 || bus.Flush_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h halted=%b valid=%b instr=%h ifid_pc=%h mis=%b fetch=%0d flush=%0d required all reset values",
               bus.Cur_PC, bus.Halted, bus.IfId_Valid, bus.IfId_Instr, bus.IfId_PC, bus.Misalign, bus.Fetch_cnt, bus.Flush_cnt);
    end
    #1;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_counters();
    logic [31:0] exp_fetch, exp_flush;
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0022, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    exp_fetch = 32'd10; exp_flush = 32'd2;
`else
    exp_fetch = 32'd0;  exp_flush = 32'd0;
`endif
    n_checks++;
    if (bus.Fetch_cnt !== exp_fetch || bus.Flush_cnt !== exp_flush) begin
      n_fail++;
      $display("FAIL perf_counters: fetch=%0d flush=%0d required %0d %0d",
               bus.Fetch_cnt, bus.Flush_cnt, exp_fetch, exp_flush);
    end
  endtask

  task automatic test_random();
    logic        st, ps, hc;
    logic [31:0] br, exp_fetch, exp_flush;
    for (int i = 0; i < 128; i++) rom[i] = $urandom;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      st = ($urandom_range(0, 3) == 0);
      ps = ($urandom_range(0, 7) == 0);
      hc = ($urandom_range(0, 9) == 0);
      br = $urandom;
      step(st, ps, br, hc);
`ifdef FETCH_PERF_CNT_EN
      exp_fetch = m_fetch; exp_flush = m_flush;
`else
      exp_fetch = 32'd0;   exp_flush = 32'd0;
`endif
      n_checks++;
      if (bus.Cur_PC !== 9'(m_pc) || bus.Instr_addr !== 9'(m_pc) || bus.IfId_Valid !== m_valid ||
          bus.IfId_Instr !== m_instr || (m_valid && bus.IfId_PC !== 9'(m_ifid_pc)) ||
          bus.Halted !== m_halted || bus.Misalign !== m_mis ||
          bus.Fetch_cnt !== exp_fetch || bus.Flush_cnt !== exp_flush) begin
        n_fail++;
        $display("FAIL random[%0d]: pc=%h valid=%b instr=%h ifid_pc=%h halted=%b mis=%b cnt=%0d/%0d required pc=%h valid=%b instr=%h ifid_pc=%h halted=%b mis=%b cnt=%0d/%0d",
                 n, bus.Cur_PC, bus.IfId_Valid, bus.IfId_Instr, bus.IfId_PC, bus.Halted, bus.Misalign,
                 bus.Fetch_cnt, bus.Flush_cnt, 9'(m_pc), m_valid, m_instr, 9'(m_ifid_pc), m_halted, m_mis,
                 exp_fetch, exp_flush);
      end
      if (m_halted && $urandom_range(0, 3) == 0) begin
        reset = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    for (int i = 0; i < 128; i++) rom[i] = 32'(i);
    bus.Stall = 0; bus.PcSel = 0; bus.BrPC = 0; bus.Halt_com = 0;
    #2;
    test_reset();
    test_sequential();
    test_wrap();
    test_stall();
    test_redirect_stall();
    test_halt();
    test_async_reset();
    test_counters();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
